// File: rtl/register_writeback_unit_pkg.sv
// Shared defaults and entry layout for the buffered register-file writeback unit.
package register_writeback_unit_pkg;

  localparam int DEPTH_DEF      = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/register_writeback_unit_wb_fifo.sv
// In-order FIFO for pending register writes; exposes every slot plus a per-slot
// valid vector so the top level can search queued writes by age.
module wb_fifo
  import register_writeback_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int EW    = ADDR_WIDTH_DEF + DATA_WIDTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [EW-1:0]            push_entry,
  input  logic                     pop,
  output logic [EW-1:0]            head_entry,
  output logic [PW-1:0]            head_ptr,
  output logic [DEPTH-1:0][EW-1:0] entries,
  output logic [DEPTH-1:0]         valid_vec,
  output logic [CW-1:0]            count
);

  logic [DEPTH-1:0][EW-1:0] mem;
  logic [PW-1:0]            head_q;
  logic [PW-1:0]            tail_q;
  logic [CW-1:0]            count_q;
  logic [PW-1:0]            offset;

  // Storage is not cleared on reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[tail_q] <= push_entry;
        tail_q      <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    offset    = '0;
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - head_q;
      valid_vec[i] = CW'(offset) < count_q;
    end
  end

  assign head_entry = mem[head_q];
  assign head_ptr   = head_q;
  assign entries    = mem;
  assign count      = count_q;

endmodule

// File: rtl/register_writeback_unit.sv
// Buffers late register results and drains them into the register file write
// port whenever the pipeline's own writeback is not using it.
module register_writeback_unit
  import register_writeback_unit_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  sig_hold,
  output logic [ADDR_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0] wd3,
  output logic                  sig_RegWrite,
  input  logic [ADDR_WIDTH-1:0] lk_addr1,
  input  logic [ADDR_WIDTH-1:0] lk_addr2,
  output logic                  lk_hit1,
  output logic                  lk_hit2,
  output logic [DATA_WIDTH-1:0] lk_data1,
  output logic [DATA_WIDTH-1:0] lk_data2,
  output logic [CW-1:0]         count
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic                     push;
  logic                     pop;
  logic                     not_empty;
  logic [EW-1:0]            head_entry;
  logic [PW-1:0]            head_ptr;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]         valid_vec;
  logic [PW-1:0]            idx;

  // Writes to $0 are acknowledged but never queued.
  assign in_ready     = reset_n && (count < CW'(DEPTH));
  assign push         = in_valid && in_ready && (in_addr != '0);
  assign not_empty    = (count != '0);
  assign sig_RegWrite = not_empty && !sig_hold;
  assign pop          = sig_RegWrite;
  assign a3           = not_empty ? head_entry[EW-1:DATA_WIDTH] : '0;
  assign wd3          = not_empty ? head_entry[DATA_WIDTH-1:0]  : '0;

  wb_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry ({in_addr, in_data}),
    .pop        (pop),
    .head_entry (head_entry),
    .head_ptr   (head_ptr),
    .entries    (entries),
    .valid_vec  (valid_vec),
    .count      (count)
  );

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PW'(k);
      if (valid_vec[idx] && (lk_addr1 != '0) &&
          (entries[idx][EW-1:DATA_WIDTH] == lk_addr1)) begin
        lk_hit1  = 1'b1;
        lk_data1 = entries[idx][DATA_WIDTH-1:0];
      end
      if (valid_vec[idx] && (lk_addr2 != '0) &&
          (entries[idx][EW-1:DATA_WIDTH] == lk_addr2)) begin
        lk_hit2  = 1'b1;
        lk_data2 = entries[idx][DATA_WIDTH-1:0];
      end
    end
  end

endmodule
